// File: rtl/keycode_events.sv
// Synchronises a NIOS keycode and the VGA vsync into the Clk domain, then turns
// frame-sampled key transitions into jump, pause and restart events.
// Optional jump auto-repeat at saturation: define KEYCODE_EVENTS_REPEAT_EN.
module keycode_events #(
    parameter logic [7:0]  JUMP_CODE      = 8'h1A,
    parameter logic [7:0]  PAUSE_CODE     = 8'h13,
    parameter logic [7:0]  RESTART_CODE   = 8'h15,
    parameter int unsigned RESTART_FRAMES = 30,
    parameter int unsigned HOLD_MAX       = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_clk,
    output logic       jump_pulse,
    output logic [3:0] jump_hold,
    output logic       paused,
    output logic       restart_pulse,
    output logic       frame_tick
);

    localparam logic [3:0] HOLD_MAX_C       = 4'(HOLD_MAX);
    localparam logic [5:0] RESTART_FRAMES_C = 6'(RESTART_FRAMES);

    typedef enum logic [0:0] {
        JMP_IDLE = 1'b0,
        JMP_HELD = 1'b1
    } jump_state_e;

    logic [7:0]  key_s1_q;
    logic [7:0]  key_s2_q;
    logic [7:0]  key_s3_q;
    logic [7:0]  key_filt_q;
    logic [7:0]  prev_code_q;
    logic        frm_s1_q;
    logic        frm_s2_q;
    logic        frm_prev_q;
    logic        tick_q;

    jump_state_e jump_state_q;
    logic        jump_pulse_q;
    logic [3:0]  jump_hold_q;
`ifdef KEYCODE_EVENTS_REPEAT_EN
    logic [2:0]  repeat_cnt_q;
`endif

    logic        paused_q;
    logic        paused_d;
    logic [5:0]  restart_cnt_q;
    logic [5:0]  restart_cnt_d;
    logic        restart_pulse_q;
    logic        restart_pulse_d;

    logic        jump_press_s;
    logic        jump_release_s;
    logic        pause_press_s;
    logic        restart_held_s;

    // Keycode synchroniser; filtered code only follows two equal synchronised samples
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_s1_q   <= 8'h00;
            key_s2_q   <= 8'h00;
            key_s3_q   <= 8'h00;
            key_filt_q <= 8'h00;
        end else begin
            key_s1_q <= keycode;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            if (key_s2_q == key_s3_q) begin
                key_filt_q <= key_s2_q;
            end else begin
                key_filt_q <= key_filt_q;
            end
        end
    end

    // Frame clock synchroniser and rising-edge detector
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frm_s1_q   <= 1'b0;
            frm_s2_q   <= 1'b0;
            frm_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            frm_s1_q   <= frame_clk;
            frm_s2_q   <= frm_s1_q;
            frm_prev_q <= frm_s2_q;
            tick_q     <= frm_s2_q & ~frm_prev_q;
        end
    end

    // Code seen at the previous frame tick, the reference for press/release
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_code_q <= 8'h00;
        end else if (tick_q) begin
            prev_code_q <= key_filt_q;
        end else begin
            prev_code_q <= prev_code_q;
        end
    end

    // Press/release decode, qualified by the frame tick
    always_comb begin
        jump_press_s   = tick_q & (key_filt_q == JUMP_CODE) & (prev_code_q != JUMP_CODE);
        jump_release_s = tick_q & (key_filt_q != JUMP_CODE) & (prev_code_q == JUMP_CODE);
        pause_press_s  = tick_q & (key_filt_q == PAUSE_CODE) & (prev_code_q != PAUSE_CODE);
        restart_held_s = tick_q & (key_filt_q == RESTART_CODE);
    end

    // Jump FSM with registered pulse and saturating hold counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            jump_state_q <= JMP_IDLE;
            jump_pulse_q <= 1'b0;
            jump_hold_q  <= 4'd0;
`ifdef KEYCODE_EVENTS_REPEAT_EN
            repeat_cnt_q <= 3'd0;
`endif
        end else begin
            jump_pulse_q <= 1'b0;
            if (tick_q) begin
                case (jump_state_q)
                    JMP_IDLE: begin
                        if (jump_press_s) begin
                            jump_state_q <= JMP_HELD;
                            jump_pulse_q <= 1'b1;
                            jump_hold_q  <= 4'd1;
`ifdef KEYCODE_EVENTS_REPEAT_EN
                            repeat_cnt_q <= 3'd0;
`endif
                        end else begin
                            jump_state_q <= JMP_IDLE;
                            jump_hold_q  <= 4'd0;
                        end
                    end
                    JMP_HELD: begin
                        if (jump_release_s) begin
                            jump_state_q <= JMP_IDLE;
                            jump_hold_q  <= 4'd0;
`ifdef KEYCODE_EVENTS_REPEAT_EN
                            repeat_cnt_q <= 3'd0;
`endif
                        end else if (jump_hold_q < HOLD_MAX_C) begin
                            jump_state_q <= JMP_HELD;
                            jump_hold_q  <= jump_hold_q + 4'd1;
                        end else begin
                            jump_state_q <= JMP_HELD;
                            jump_hold_q  <= jump_hold_q;
`ifdef KEYCODE_EVENTS_REPEAT_EN
                            // Counter wraps naturally: a pulse every eighth saturated tick
                            if (repeat_cnt_q == 3'd7) begin
                                jump_pulse_q <= 1'b1;
                            end else begin
                                jump_pulse_q <= 1'b0;
                            end
                            repeat_cnt_q <= repeat_cnt_q + 3'd1;
`endif
                        end
                    end
                    default: begin
                        jump_state_q <= JMP_IDLE;
                        jump_hold_q  <= 4'd0;
                    end
                endcase
            end else begin
                jump_state_q <= jump_state_q;
                jump_hold_q  <= jump_hold_q;
            end
        end
    end

    // Long-press restart counter and pause toggle; a restart wins over a toggle
    always_comb begin
        restart_cnt_d   = restart_cnt_q;
        restart_pulse_d = 1'b0;
        paused_d        = paused_q;
        if (tick_q) begin
            if (restart_held_s) begin
                if (restart_cnt_q < RESTART_FRAMES_C) begin
                    restart_cnt_d = restart_cnt_q + 6'd1;
                    if ((restart_cnt_q + 6'd1) == RESTART_FRAMES_C) begin
                        restart_pulse_d = 1'b1;
                    end else begin
                        restart_pulse_d = 1'b0;
                    end
                end else begin
                    restart_cnt_d = restart_cnt_q;
                end
            end else begin
                restart_cnt_d = 6'd0;
            end
            if (restart_pulse_d) begin
                paused_d = 1'b0;
            end else if (pause_press_s) begin
                paused_d = ~paused_q;
            end else begin
                paused_d = paused_q;
            end
        end else begin
            restart_cnt_d = restart_cnt_q;
        end
    end

    // Pause/restart state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            restart_cnt_q   <= 6'd0;
            restart_pulse_q <= 1'b0;
            paused_q        <= 1'b0;
        end else begin
            restart_cnt_q   <= restart_cnt_d;
            restart_pulse_q <= restart_pulse_d;
            paused_q        <= paused_d;
        end
    end

    assign jump_pulse    = jump_pulse_q;
    assign jump_hold     = jump_hold_q;
    assign paused        = paused_q;
    assign restart_pulse = restart_pulse_q;
    assign frame_tick    = tick_q;

endmodule

// File: doc/keycode_events.md
KEYCODE_EVENTS -- requirements
Module: keycode_events

Interface
REQ-001 Parameter JUMP_CODE, default 8'h1A: USB keycode for jump (W).
REQ-002 Parameter PAUSE_CODE, default 8'h13: keycode for pause toggle (P).
REQ-003 Parameter RESTART_CODE, default 8'h15: keycode for restart (R).
REQ-004 Parameter RESTART_FRAMES, default 30: frames R must be held before restart fires.
REQ-005 Parameter HOLD_MAX, default 15: saturation value of jump_hold.
REQ-006 Clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 keycode  input  8  keycode from the NIOS PIO, asynchronous to frame timing, bits may skew.
REQ-009 frame_clk  input  1  VGA_VS; rising edge marks a new frame.
REQ-010 jump_pulse  output  1  one-Clk pulse per accepted jump event.
REQ-011 jump_hold  output  4  frames jump key held, saturating at HOLD_MAX.
REQ-012 paused  output  1  pause level, toggled by each PAUSE_CODE press.
REQ-013 restart_pulse  output  1  one-Clk pulse on completed long-press of RESTART_CODE.
REQ-014 frame_tick  output  1  one-Clk pulse per detected frame edge.

Function
REQ-015 keycode SHALL pass a 2-flop synchronizer; filtered code SHALL update only when the synchronized value is equal on 2 consecutive Clk edges, else hold.
REQ-016 frame_clk SHALL pass a 2-flop synchronizer plus one edge register; frame_tick SHALL assert for exactly one Clk when synchronized value is 1 and previous is 0.
REQ-017 All key decisions SHALL occur only in the frame_tick cycle, using the filtered code; event outputs SHALL be registered and appear on the Clk edge after frame_tick.
REQ-018 A press SHALL be: filtered code == X at this tick and != X at previous tick; release is the reverse.
REQ-019 jump FSM states IDLE, HELD: IDLE->HELD on jump press (jump_pulse=1, jump_hold=1); HELD: jump_hold +1 per tick, saturating at HOLD_MAX; HELD->IDLE on release (jump_hold=0 same update).
REQ-020 paused SHALL invert on each PAUSE_CODE press; holding P SHALL not re-toggle.
REQ-021 Restart counter (6-bit) SHALL count ticks while RESTART_CODE held; restart_pulse SHALL fire once when count reaches RESTART_FRAMES, counter then holds until release; release before threshold clears counter, no pulse.
REQ-022 restart_pulse SHALL also clear paused to 0 in the same update.
REQ-023 Keycode changing directly from one watched code to another SHALL be release of the first and press of the second in the same tick.
REQ-024 Code changes shorter than one frame period SHALL be invisible; no event without a frame_tick.
REQ-025 jump_pulse and restart_pulse MAY assert in the same cycle only if codes coincide; otherwise mutually exclusive by construction.

Reset
REQ-026 Reset_n low SHALL asynchronously clear all flops: all outputs 0, FSM IDLE, counters 0, previous code 8'h00.
REQ-027 Key held through reset release SHALL register as a press at the first frame_tick after reset.
REQ-028 Reset mid-hold or mid-long-press SHALL discard progress; no pulse after reset without a new press.

Configuration
REQ-029 Macro KEYCODE_EVENTS_REPEAT_EN defined: while HELD and jump_hold == HOLD_MAX, jump_pulse SHALL repeat every 8th frame_tick (3-bit repeat counter, cleared on release).
REQ-030 Macro undefined: exactly one jump_pulse per press; repeat counter absent.

Verification
REQ-031 Reset low, 1 frame_clk period later release; keycode=8'h1A held -> jump_pulse exactly once, 1 Clk after first frame_tick; jump_hold 1,2..15 then stays 15.
REQ-032 keycode 8'h13 for 3 frames, 0 for 2, 8'h13 for 3 -> paused 0->1->0, one toggle per press.
REQ-033 keycode 8'h15 held 29 frames then 0 -> no restart_pulse; held 40 frames -> one restart_pulse at tick 30, paused forced 0.
REQ-034 keycode glitch 8'h1A for 1 Clk between frames and bit-skewed transitions -> no jump_pulse, jump_hold stays 0.
REQ-035 8'h1A held, Reset_n pulsed low at jump_hold=7 -> outputs 0 immediately; press re-detected at next tick, jump_hold restarts at 1.
REQ-036 With KEYCODE_EVENTS_REPEAT_EN, 8'h1A held 40 frames -> pulses at ticks 1, 23, 31, 39; without macro -> only tick 1.
